// File: rtl/multicycle_decoder.sv
// Multicycle control FSM for the ARM subset (DP reg/imm, LDR/STR, B).
// Adds a memory stall handshake, a not-ready timeout fault and condition-gated writes.
module multicycle_decoder #(
  parameter int ALU_CONTROL_WIDTH = 3,
  parameter bit EXTENDED_ALU      = 1'b1,
  parameter int MEMORY_TIMEOUT    = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [1:0]                   operation_code,
  input  logic [5:0]                   function_id,
  input  logic [3:0]                   destination_register,
  input  logic                         condition_pass,
  input  logic                         memory_ready,
  output logic                         instruction_register_write,
  output logic                         program_counter_write,
  output logic                         address_source,
  output logic                         register_write_enable,
  output logic                         memory_write_enable,
  output logic [1:0]                   result_source,
  output logic                         alu_source_a,
  output logic [1:0]                   alu_source_b,
  output logic [1:0]                   immediate_source,
  output logic [1:0]                   register_source,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_control,
  output logic [1:0]                   flag_write,
  output logic                         fault,
  output logic [3:0]                   state
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC += 4 when memory is ready
  // DECODE   | register read, PC+8 computed, dispatch on opcode
  // MEMADR   | base + offset address for LDR/STR
  // MEMREAD  | wait for load data
  // MEMWB    | write load data to Rd
  // MEMWRITE | store data (condition gated)
  // EXECUTER | DP with register operand
  // EXECUTEI | DP with immediate operand
  // ALUWB    | write ALU result to Rd
  // BRANCH   | PC <- PC+8 + offset (condition gated)
  // FAULT    | sticky halt until reset
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    FAULT    = 4'd15
  } state_t;

  localparam int CNT_W = (MEMORY_TIMEOUT > 1) ? $clog2(MEMORY_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEMORY_TIMEOUT > 0) ? MEMORY_TIMEOUT - 1 : 0);

  state_t           cur_state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting, timeout_hit;

  logic [3:0] cmd;
  logic       s_bit;
  logic       is_add, is_sub, is_and, is_orr, is_eor, is_cmp, is_mov, cmd_ok;
  logic [2:0] alu_sel;

  assign cmd    = function_id[4:1];
  assign s_bit  = function_id[0];
  assign is_add = (cmd == 4'b0100);
  assign is_sub = (cmd == 4'b0010);
  assign is_and = (cmd == 4'b0000);
  assign is_orr = (cmd == 4'b1100);
  assign is_eor = EXTENDED_ALU && (cmd == 4'b0001);
  assign is_cmp = EXTENDED_ALU && (cmd == 4'b1010);
  assign is_mov = EXTENDED_ALU && (cmd == 4'b1101);
  assign cmd_ok = is_add | is_sub | is_and | is_orr | is_eor | is_cmp | is_mov;

  always_comb begin
    alu_sel = 3'b000;
    if (is_sub || is_cmp) alu_sel = 3'b001;
    else if (is_and)      alu_sel = 3'b010;
    else if (is_orr)      alu_sel = 3'b011;
    else if (is_eor)      alu_sel = 3'b100;
    else if (is_mov)      alu_sel = 3'b101;
  end

  // Ready in the last allowed cycle still wins over the timeout.
  assign waiting     = ((cur_state == FETCH) || (cur_state == MEMREAD)) && !memory_ready;
  assign timeout_hit = (MEMORY_TIMEOUT != 0) && waiting && (wait_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= FETCH;
      wait_cnt  <= '0;
    end else begin
      cur_state <= next_state;
      if (waiting && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                         wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state                 = cur_state;
    instruction_register_write = 1'b0;
    program_counter_write      = 1'b0;
    address_source             = 1'b0;
    register_write_enable      = 1'b0;
    memory_write_enable        = 1'b0;
    result_source              = 2'b00;
    alu_source_a               = 1'b0;
    alu_source_b               = 2'b00;
    immediate_source           = 2'b00;
    register_source            = 2'b00;
    alu_control                = '0;
    flag_write                 = 2'b00;

    if (cur_state != FETCH && cur_state != FAULT) begin
      immediate_source = operation_code;
      register_source  = {operation_code == 2'b10, operation_code == 2'b01};
    end

    case (cur_state)
      FETCH: begin
        alu_source_a  = 1'b1;
        alu_source_b  = 2'b10;
        result_source = 2'b10;
        if (timeout_hit) next_state = FAULT;
        else if (memory_ready) begin
          // Gated by reset_n so nothing is latched while reset is held.
          instruction_register_write = reset_n;
          program_counter_write      = reset_n;
          next_state                 = DECODE;
        end
      end
      DECODE: begin
        alu_source_a  = 1'b1;
        alu_source_b  = 2'b10;
        result_source = 2'b10;
        case (operation_code)
          2'b00:   next_state = !cmd_ok ? FAULT : (function_id[5] ? EXECUTEI : EXECUTER);
          2'b01:   next_state = MEMADR;
          2'b10:   next_state = BRANCH;
          default: next_state = FAULT;
        endcase
      end
      EXECUTER, EXECUTEI: begin
        alu_source_b  = (cur_state == EXECUTEI) ? 2'b01 : 2'b00;
        alu_control   = ALU_CONTROL_WIDTH'(alu_sel);
        flag_write[1] = (s_bit | is_cmp) & condition_pass;
        flag_write[0] = (s_bit | is_cmp) & (is_add | is_sub | is_cmp) & condition_pass;
        next_state    = ALUWB;
      end
      ALUWB: begin
        register_write_enable = condition_pass & !is_cmp;
        program_counter_write = condition_pass & !is_cmp & (destination_register == 4'd15);
        next_state            = FETCH;
      end
      MEMADR: begin
        alu_source_b = 2'b01;
        next_state   = function_id[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        address_source = 1'b1;
        if (timeout_hit)       next_state = FAULT;
        else if (memory_ready) next_state = MEMWB;
      end
      MEMWB: begin
        result_source         = 2'b01;
        register_write_enable = condition_pass;
        program_counter_write = condition_pass & (destination_register == 4'd15);
        next_state            = FETCH;
      end
      MEMWRITE: begin
        address_source      = 1'b1;
        memory_write_enable = condition_pass;
        next_state          = FETCH;
      end
      BRANCH: begin
        alu_source_b          = 2'b01;
        result_source         = 2'b10;
        program_counter_write = condition_pass;
        next_state            = FETCH;
      end
      FAULT:   next_state = FAULT;
      default: next_state = FAULT;
    endcase
  end

  assign fault = (cur_state == FAULT);
  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: walks each instruction class state by state
// against hand-computed control values, plus timeout and reset cases.
module tb_multicycle_decoder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] operation_code;
  logic [5:0] function_id;
  logic [3:0] destination_register;
  logic       condition_pass;
  logic       memory_ready;

  logic       ir_write, pc_write, addr_src, reg_write, mem_write, fault;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src, flag_write;
  logic       alu_src_a;
  logic [2:0] alu_control;
  logic [3:0] state;

  logic       x_ir_write, x_pc_write, x_addr_src, x_reg_write, x_mem_write, x_fault;
  logic [1:0] x_result_src, x_alu_src_b, x_imm_src, x_reg_src, x_flag_write;
  logic       x_alu_src_a;
  logic [2:0] x_alu_control;
  logic [3:0] x_state;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  multicycle_decoder #(.ALU_CONTROL_WIDTH(3), .EXTENDED_ALU(1'b1), .MEMORY_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .operation_code(operation_code),
    .function_id(function_id), .destination_register(destination_register),
    .condition_pass(condition_pass), .memory_ready(memory_ready),
    .instruction_register_write(ir_write), .program_counter_write(pc_write),
    .address_source(addr_src), .register_write_enable(reg_write),
    .memory_write_enable(mem_write), .result_source(result_src),
    .alu_source_a(alu_src_a), .alu_source_b(alu_src_b), .immediate_source(imm_src),
    .register_source(reg_src), .alu_control(alu_control), .flag_write(flag_write),
    .fault(fault), .state(state)
  );

  multicycle_decoder #(.ALU_CONTROL_WIDTH(3), .EXTENDED_ALU(1'b0), .MEMORY_TIMEOUT(16)) dut_base (
    .clock(clock), .reset_n(reset_n), .operation_code(operation_code),
    .function_id(function_id), .destination_register(destination_register),
    .condition_pass(condition_pass), .memory_ready(memory_ready),
    .instruction_register_write(x_ir_write), .program_counter_write(x_pc_write),
    .address_source(x_addr_src), .register_write_enable(x_reg_write),
    .memory_write_enable(x_mem_write), .result_source(x_result_src),
    .alu_source_a(x_alu_src_a), .alu_source_b(x_alu_src_b), .immediate_source(x_imm_src),
    .register_source(x_reg_src), .alu_control(x_alu_control), .flag_write(x_flag_write),
    .fault(x_fault), .state(x_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fid,
                           input logic [3:0] rd, input logic pass);
    operation_code       = op;
    function_id          = fid;
    destination_register = rd;
    condition_pass       = pass;
  endtask

  initial begin
    reset_n      = 1'b0;
    memory_ready = 1'b0;
    set_instr(2'b00, 6'b000000, 4'd0, 1'b0);
    #12;
    check_eq("rst_state", state, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_ir_write", ir_write, 0);
    check_eq("rst_reg_write", reg_write, 0);
    tick();
    reset_n = 1'b1;

    // ADD r1, S=1
    set_instr(2'b00, 6'b001001, 4'd1, 1'b1);
    memory_ready = 1'b1;
    #1;
    check_eq("add_f_state", state, 0);
    check_eq("add_f_ir", ir_write, 1);
    check_eq("add_f_pc", pc_write, 1);
    check_eq("add_f_asrc", alu_src_a, 1);
    check_eq("add_f_bsrc", alu_src_b, 2);
    check_eq("add_f_res", result_src, 2);
    tick(); check_eq("add_d_state", state, 1);
    tick();
    check_eq("add_er_state", state, 6);
    check_eq("add_er_alu", alu_control, 0);
    check_eq("add_er_flags", flag_write, 3);
    check_eq("add_er_bsrc", alu_src_b, 0);
    check_eq("add_er_regw", reg_write, 0);
    tick();
    check_eq("add_aw_state", state, 8);
    check_eq("add_aw_regw", reg_write, 1);
    check_eq("add_aw_res", result_src, 0);
    check_eq("add_aw_pc", pc_write, 0);
    tick(); check_eq("add_end_state", state, 0);

    // LDR r2 with three stall cycles in MEMREAD
    set_instr(2'b01, 6'b011001, 4'd2, 1'b1);
    #1;
    tick();
    check_eq("ldr_d_state", state, 1);
    check_eq("ldr_d_imm", imm_src, 1);
    check_eq("ldr_d_regsrc", reg_src, 1);
    tick();
    check_eq("ldr_ma_state", state, 2);
    check_eq("ldr_ma_bsrc", alu_src_b, 1);
    memory_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("ldr_mr_state", state, 3);
      check_eq("ldr_mr_addr", addr_src, 1);
      check_eq("ldr_mr_regw", reg_write, 0);
      tick();
    end
    memory_ready = 1'b1;
    #1;
    check_eq("ldr_mr_last", state, 3);
    tick();
    check_eq("ldr_wb_state", state, 4);
    check_eq("ldr_wb_regw", reg_write, 1);
    check_eq("ldr_wb_res", result_src, 1);
    tick();
    check_eq("ldr_end_state", state, 0);
    check_eq("ldr_end_regw", reg_write, 0);

    // B with condition failing
    set_instr(2'b10, 6'b100000, 4'd0, 1'b0);
    #1;
    tick(); tick();
    check_eq("b_state", state, 9);
    check_eq("b_pc", pc_write, 0);
    check_eq("b_asrc", alu_src_a, 0);
    check_eq("b_bsrc", alu_src_b, 1);
    check_eq("b_res", result_src, 2);
    check_eq("b_regsrc", reg_src, 2);
    condition_pass = 1'b1;
    #1;
    check_eq("b_pc_pass", pc_write, 1);
    tick(); check_eq("b_end_state", state, 0);

    // STR with condition failing, then passing in the same cycle
    set_instr(2'b01, 6'b011000, 4'd3, 1'b0);
    #1;
    tick(); tick();
    check_eq("str_ma_state", state, 2);
    tick();
    check_eq("str_mw_state", state, 5);
    check_eq("str_mw_memw", mem_write, 0);
    check_eq("str_mw_addr", addr_src, 1);
    condition_pass = 1'b1;
    #1;
    check_eq("str_mw_memw_pass", mem_write, 1);
    tick();
    check_eq("str_end_state", state, 0);
    check_eq("str_end_memw", mem_write, 0);

    // CMP: extended instance executes, base instance faults from DECODE
    set_instr(2'b00, 6'b010101, 4'd0, 1'b1);
    #1;
    tick();
    check_eq("cmp_d_state", state, 1);
    check_eq("cmp_base_d_state", x_state, 1);
    tick();
    check_eq("cmp_er_state", state, 6);
    check_eq("cmp_er_alu", alu_control, 1);
    check_eq("cmp_er_flags", flag_write, 3);
    check_eq("cmp_base_state", x_state, 15);
    check_eq("cmp_base_fault", x_fault, 1);
    tick();
    check_eq("cmp_aw_state", state, 8);
    check_eq("cmp_aw_regw", reg_write, 0);
    tick();

    // MOV immediate, S=0
    set_instr(2'b00, 6'b111010, 4'd4, 1'b1);
    #1;
    tick(); tick();
    check_eq("mov_ei_state", state, 7);
    check_eq("mov_ei_alu", alu_control, 5);
    check_eq("mov_ei_flags", flag_write, 0);
    check_eq("mov_ei_bsrc", alu_src_b, 1);
    tick(); check_eq("mov_aw_regw", reg_write, 1);
    tick();

    // ORR S=1: flags gated by condition, ORR only writes NZ
    set_instr(2'b00, 6'b011001, 4'd5, 1'b0);
    #1;
    tick(); tick();
    check_eq("orr_er_alu", alu_control, 3);
    check_eq("orr_er_flags_fail", flag_write, 0);
    condition_pass = 1'b1;
    #1;
    check_eq("orr_er_flags_pass", flag_write, 2);
    tick(); check_eq("orr_aw_regw", reg_write, 1);
    tick();

    // ADD Rd=15 writes PC in ALUWB
    set_instr(2'b00, 6'b001000, 4'd15, 1'b1);
    #1;
    tick(); tick(); tick();
    check_eq("pc15_aw_state", state, 8);
    check_eq("pc15_aw_regw", reg_write, 1);
    check_eq("pc15_aw_pc", pc_write, 1);
    condition_pass = 1'b0;
    #1;
    check_eq("pc15_aw_pc_fail", pc_write, 0);
    check_eq("pc15_aw_regw_fail", reg_write, 0);
    tick();

    // 15 not-ready cycles then ready on the 16th: no fault
    set_instr(2'b00, 6'b001001, 4'd1, 1'b1);
    memory_ready = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) begin
      check_eq("tob_wait_ir", ir_write, 0);
      tick();
    end
    memory_ready = 1'b1;
    #1;
    check_eq("tob_ready_ir", ir_write, 1);
    tick();
    check_eq("tob_decode", state, 1);
    check_eq("tob_nofault", fault, 0);
    tick(); tick(); tick();
    check_eq("tob_end_state", state, 0);

    // 16 not-ready cycles: FAULT, sticky
    memory_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check_eq("to_wait_state", state, 0);
      tick();
    end
    check_eq("to_state", state, 15);
    check_eq("to_fault", fault, 1);
    memory_ready = 1'b1;
    #1;
    check_eq("to_ir", ir_write, 0);
    check_eq("to_pc", pc_write, 0);
    tick(); tick();
    check_eq("to_sticky_state", state, 15);
    check_eq("to_sticky_fault", fault, 1);

    // Reset clears the fault; reset in MEMWB aborts the write
    reset_n = 1'b0;
    #1;
    check_eq("rst2_state", state, 0);
    check_eq("rst2_fault", fault, 0);
    check_eq("rst2_base_fault", x_fault, 0);
    check_eq("rst2_ir_gated", ir_write, 0);
    tick();
    reset_n = 1'b1;
    set_instr(2'b01, 6'b011001, 4'd7, 1'b1);
    #1;
    tick(); tick(); tick(); tick();
    check_eq("rstwb_state", state, 4);
    check_eq("rstwb_regw", reg_write, 1);
    reset_n = 1'b0;
    #1;
    check_eq("rstwb_after_state", state, 0);
    check_eq("rstwb_after_regw", reg_write, 0);
    check_eq("rstwb_after_pc", pc_write, 0);
    tick();
    reset_n = 1'b1;
    #1;
    check_eq("rstwb_release_state", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
